// File: rtl/esfa_pkg.sv
// Shared definitions for the ESFA self-test block: defaults, op/state enums and the fixed script.
package esfa_pkg;

  localparam int unsigned DATA_W_DEF       = 8;
  localparam int unsigned ARRAY_SIZE_DEF   = 8;
  localparam int unsigned MAX_VERSIONS_DEF = 8;
  localparam int unsigned SCRIPT_LEN       = 12;

  typedef enum logic {
    OP_UPD = 1'b0,
    OP_LKP = 1'b1
  } op_t;

  typedef struct packed {
    op_t        op;
    logic [7:0] ver;
    logic [7:0] idx;
    logic [7:0] val;
  } script_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // For UPD entries val is the element written; for LKP entries it is the expected read value.
  localparam script_t [0:SCRIPT_LEN-1] SCRIPT = '{
    '{OP_UPD, 8'd0, 8'd0, 8'h11},
    '{OP_UPD, 8'd1, 8'd1, 8'h22},
    '{OP_UPD, 8'd0, 8'd0, 8'h33},
    '{OP_LKP, 8'd1, 8'd0, 8'h11},
    '{OP_LKP, 8'd2, 8'd1, 8'h22},
    '{OP_LKP, 8'd2, 8'd0, 8'h11},
    '{OP_LKP, 8'd3, 8'd0, 8'h33},
    '{OP_LKP, 8'd3, 8'd1, 8'h00},
    '{OP_LKP, 8'd0, 8'd0, 8'h00},
    '{OP_UPD, 8'd2, 8'd7, 8'h7F},
    '{OP_LKP, 8'd4, 8'd7, 8'h7F},
    '{OP_LKP, 8'd4, 8'd1, 8'h22}
  };

endpackage

// File: rtl/esfa_core.sv
// Versioned functional array: every update creates a new row copied from an older version.
module esfa_core
  import esfa_pkg::*;
#(
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned ARRAY_SIZE   = ARRAY_SIZE_DEF,
  parameter int unsigned MAX_VERSIONS = MAX_VERSIONS_DEF,
  parameter int unsigned VER_W        = $clog2(MAX_VERSIONS),
  parameter int unsigned IDX_W        = $clog2(ARRAY_SIZE)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              upd_en,
  input  logic [VER_W-1:0]  ver,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              error
);

  localparam int unsigned NF_W = $clog2(MAX_VERSIONS + 1);

  logic [DATA_W-1:0] r_mem [MAX_VERSIONS][ARRAY_SIZE];
  logic [NF_W-1:0]   r_next_free;
  logic              r_error;
  logic              w_ver_bad;
  logic              w_full;

  assign w_ver_bad = (NF_W'(ver) >= r_next_free);
  assign w_full    = (r_next_free == NF_W'(MAX_VERSIONS));
  assign rdata     = r_mem[ver][idx];
  assign error     = r_error;

  // Any cycle without an update is treated as a lookup of ver, so idle callers must park ver at 0.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      for (int unsigned v = 0; v < MAX_VERSIONS; v++)
        for (int unsigned j = 0; j < ARRAY_SIZE; j++)
          r_mem[v][j] <= '0;
      r_next_free <= NF_W'(1);
      r_error     <= 1'b0;
    end else if (upd_en) begin
      if (w_full || w_ver_bad) begin
        r_error <= 1'b1;
      end else begin
        for (int unsigned j = 0; j < ARRAY_SIZE; j++)
          r_mem[r_next_free[VER_W-1:0]][j] <= (IDX_W'(j) == idx) ? wdata : r_mem[ver][j];
        r_next_free <= r_next_free + NF_W'(1);
      end
    end else if (w_ver_bad) begin
      r_error <= 1'b1;
    end
  end

endmodule

// File: rtl/esfa_top.sv
// Self-test sequencer: replays the constant script against esfa_core and reports pass/fail.
module esfa_top
  import esfa_pkg::*;
#(
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned ARRAY_SIZE   = ARRAY_SIZE_DEF,
  parameter int unsigned MAX_VERSIONS = MAX_VERSIONS_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic doRun,
  output logic isRunning,
  output logic wasSuccessful
);

  localparam int unsigned VER_W = $clog2(MAX_VERSIONS);
  localparam int unsigned IDX_W = $clog2(ARRAY_SIZE);

  state_t            r_state;
  logic [3:0]        r_ptr;
  logic              r_mismatch;
  logic              r_success;

  logic              w_active;
  logic              w_is_lkp;
  logic              w_upd_en;
  logic              w_clear;
  logic              w_lkp_bad;
  logic              w_error;
  logic [VER_W-1:0]  w_ver;
  logic [IDX_W-1:0]  w_idx;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_rdata;

  assign w_active  = (r_state == ST_ISSUE) || (r_state == ST_CHECK);
  assign w_is_lkp  = (SCRIPT[r_ptr].op == OP_LKP);
  assign w_upd_en  = (r_state == ST_ISSUE) && !w_is_lkp;
  assign w_clear   = (r_state == ST_INIT);
  assign w_ver     = w_active ? VER_W'(SCRIPT[r_ptr].ver) : '0;
  assign w_idx     = w_active ? IDX_W'(SCRIPT[r_ptr].idx) : '0;
  assign w_wdata   = DATA_W'(SCRIPT[r_ptr].val);
  assign w_lkp_bad = (r_state == ST_CHECK) && w_is_lkp && (w_rdata != DATA_W'(SCRIPT[r_ptr].val));

  assign isRunning     = (r_state == ST_INIT) || w_active;
  assign wasSuccessful = r_success;

  esfa_core #(
    .DATA_W       (DATA_W),
    .ARRAY_SIZE   (ARRAY_SIZE),
    .MAX_VERSIONS (MAX_VERSIONS)
  ) u_core (
    .clk    (clk),
    .reset  (reset),
    .clear  (w_clear),
    .upd_en (w_upd_en),
    .ver    (w_ver),
    .idx    (w_idx),
    .wdata  (w_wdata),
    .rdata  (w_rdata),
    .error  (w_error)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_ptr      <= '0;
      r_mismatch <= 1'b0;
      r_success  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (doRun) begin
            r_state   <= ST_INIT;
            r_success <= 1'b0;
          end
        end
        ST_INIT: begin
          r_ptr      <= '0;
          r_mismatch <= 1'b0;
          r_state    <= ST_ISSUE;
        end
        ST_ISSUE: r_state <= ST_CHECK;
        ST_CHECK: begin
          if (w_lkp_bad) r_mismatch <= 1'b1;
          // The last op's own compare result is folded in directly, as r_mismatch is not yet updated.
          if (r_ptr == 4'(SCRIPT_LEN - 1)) begin
            r_state   <= ST_DONE;
            r_success <= !(r_mismatch || w_lkp_bad || w_error);
          end else begin
            r_ptr   <= r_ptr + 4'd1;
            r_state <= ST_ISSUE;
          end
        end
        ST_DONE: if (!doRun) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_esfa_top.sv
// Bench for esfa_top: directed segment table plus random reset/doRun traffic against a cycle-level model.
module tb_esfa_top;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic doRun = 1'b0;
  logic isRunning;
  logic wasSuccessful;

  int n_checks = 0;
  int n_fail   = 0;

  esfa_top #(
    .DATA_W       (8),
    .ARRAY_SIZE   (8),
    .MAX_VERSIONS (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .doRun         (doRun),
    .isRunning     (isRunning),
    .wasSuccessful (wasSuccessful)
  );

  always #5 clk = ~clk;

  // Model: a run is a fixed-length busy window whose verdict comes from executing the script on arrays.
  localparam int RUN_LEN = 25;
  int run_left    = 0;
  bit m_success   = 1'b0;
  bit wait_low    = 1'b0;
  bit script_ok;

  function automatic bit eval_script();
    int        kind [12] = '{0, 0, 0, 1, 1, 1, 1, 1, 1, 0, 1, 1};
    int        ver  [12] = '{0, 1, 0, 1, 2, 2, 3, 3, 0, 2, 4, 4};
    int        idx  [12] = '{0, 1, 0, 0, 1, 0, 0, 1, 0, 7, 7, 1};
    int        val  [12] = '{'h11, 'h22, 'h33, 'h11, 'h22, 'h11, 'h33, 'h00, 'h00, 'h7F, 'h7F, 'h22};
    int        rows [8][8];
    int        nver = 1;
    bit        bad  = 1'b0;
    for (int v = 0; v < 8; v++)
      for (int j = 0; j < 8; j++) rows[v][j] = 0;
    for (int k = 0; k < 12; k++) begin
      if (kind[k] == 0) begin
        if (nver >= 8 || ver[k] >= nver) bad = 1'b1;
        else begin
          rows[nver] = rows[ver[k]];
          rows[nver][idx[k]] = val[k];
          nver++;
        end
      end else begin
        if (ver[k] >= nver) bad = 1'b1;
        else if (rows[ver[k]][idx[k]] != val[k]) bad = 1'b1;
      end
    end
    return !bad;
  endfunction

  task automatic model_edge(input bit rst, input bit run);
    if (rst) begin
      run_left  = 0;
      m_success = 1'b0;
      wait_low  = 1'b0;
    end else if (run_left > 0) begin
      run_left--;
      if (run_left == 0) begin
        m_success = script_ok;
        wait_low  = 1'b1;
      end
    end else if (wait_low) begin
      if (!run) wait_low = 1'b0;
    end else if (run) begin
      run_left  = RUN_LEN;
      m_success = 1'b0;
    end
  endtask

  task automatic check(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic step(input bit rst, input bit run, input string tag);
    reset = rst;
    doRun = run;
    @(posedge clk);
    #1;
    model_edge(rst, run);
    check({tag, ".isRunning"}, isRunning, run_left > 0);
    check({tag, ".wasSuccessful"}, wasSuccessful, m_success);
  endtask

  typedef struct {
    bit    rst;
    bit    run;
    int    cycles;
    logic  exp_running;
    logic  exp_success;
    string name;
  } seg_t;

  seg_t segs [$];

  initial begin
    script_ok = eval_script();

    segs = '{
      '{1, 1, 15,    0, 0, "reset_hold"},
      '{0, 1, 1,     1, 0, "run1_start"},
      '{0, 1, 24,    1, 0, "run1_body"},
      '{0, 1, 1,     0, 1, "run1_done"},
      '{0, 1, 20000, 0, 1, "no_rerun"},
      '{0, 0, 1,     0, 1, "drop_1"},
      '{0, 1, 1,     1, 0, "run2_start"},
      '{0, 1, 24,    1, 0, "run2_body"},
      '{0, 1, 1,     0, 1, "run2_done"},
      '{0, 0, 1,     0, 1, "to_idle"},
      '{0, 1, 5,     1, 0, "run3_head"},
      '{0, 0, 20,    1, 0, "run3_tail_lowrun"},
      '{0, 0, 1,     0, 1, "run3_done"},
      '{0, 0, 1,     0, 1, "run3_idle"},
      '{0, 1, 10,    1, 0, "run4_partial"},
      '{1, 1, 1,     0, 0, "midrun_reset"},
      '{0, 0, 2,     0, 0, "post_reset_idle"},
      '{0, 1, 25,    1, 0, "run5_full"},
      '{0, 1, 1,     0, 1, "run5_done"}
    };

    foreach (segs[s]) begin
      for (int c = 0; c < segs[s].cycles; c++) step(segs[s].rst, segs[s].run, segs[s].name);
      check({segs[s].name, ".end_isRunning"}, isRunning, segs[s].exp_running);
      check({segs[s].name, ".end_wasSuccessful"}, wasSuccessful, segs[s].exp_success);
    end

    for (int c = 0; c < 4000; c++) begin
      bit r;
      bit d;
      r = ($urandom_range(0, 59) == 0);
      d = ($urandom_range(0, 9) < 7) ? doRun : ~doRun;
      step(r, d, "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
